// File: rtl/hit_judge.sv
// hit_judge: lane-based rhythm-game judge. Opens a timed window per note
// strobe, edge-detects presses per lane, grades GREAT/GOOD/MISS and keeps
// a saturating score, current combo and max combo.
module hit_judge #(
  parameter int NUM_LANES      = 3,
  parameter int WINDOW         = 8,
  parameter int GREAT_WINDOW   = 3,
  parameter int GREAT_PTS      = 300,
  parameter int GOOD_PTS       = 100,
  parameter int MISS_PTS       = 50,
  parameter int PENALISE_STRAY = 1,
  parameter int SCORE_W        = 16,
  parameter int COMBO_W        = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 note_valid,
  input  logic [NUM_LANES-1:0] notes,
  input  logic [NUM_LANES-1:0] player_input,
  input  logic                 clear_stats,
  output logic                 window_open,
  output logic                 judge_great,
  output logic                 judge_good,
  output logic                 judge_miss,
  output logic [SCORE_W-1:0]   score,
  output logic [COMBO_W-1:0]   combo,
  output logic [COMBO_W-1:0]   max_combo
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  // Wide enough that score + any 32-bit points value never wraps.
  localparam int AW    = SCORE_W + 33;

  typedef enum logic {IDLE, OPEN} state_t;
  typedef enum logic [1:0] {J_NONE, J_GREAT, J_GOOD, J_MISS} grade_t;

  state_t               state, state_d;
  grade_t               grade;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [NUM_LANES-1:0] expected, expected_d;
  logic [NUM_LANES-1:0] hit_mask, hit_mask_d;
  logic [NUM_LANES-1:0] prev_input;
  logic [NUM_LANES-1:0] rise, wrong, match;
  logic                 early, last;

  logic [AW-1:0]        pts, sum;
  logic [SCORE_W-1:0]   score_hit, score_miss;
  logic [COMBO_W-1:0]   combo_hit, max_hit;

  // Per-lane press edge, wrong-lane flag and "lane satisfied" flag.
  // A lane matches when its accumulated/new hit equals its requirement,
  // so an all-ones match vector means the note is complete.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign rise[l]  = player_input[l] & ~prev_input[l];
    assign wrong[l] = rise[l] & ~expected[l];
    assign match[l] = ((hit_mask[l] | rise[l]) == expected[l]);
  end

  assign early = (int'(cnt) < GREAT_WINDOW);
  assign last  = (int'(cnt) == WINDOW - 1);

  // Window control and grading decision for the current edge.
  always_comb begin
    grade      = J_NONE;
    state_d    = state;
    expected_d = expected;
    hit_mask_d = hit_mask;
    cnt_d      = cnt;
    case (state)
      IDLE: begin
        // Presses on the strobe edge are ignored; a rest note opens nothing.
        if (note_valid) begin
          if (|notes) begin
            state_d    = OPEN;
            expected_d = notes;
            hit_mask_d = '0;
            cnt_d      = '0;
          end
        end else if ((|rise) && (PENALISE_STRAY != 0)) begin
          grade = J_MISS;
        end
      end
      OPEN: begin
        // Old note is always judged first, even when a new strobe lands.
        if (|wrong)                  grade = J_MISS;
        else if (&match)             grade = early ? J_GREAT : J_GOOD;
        else if (note_valid || last) grade = J_MISS;

        if (grade != J_NONE) begin
          state_d = IDLE;
        end else begin
          hit_mask_d = hit_mask | rise;
          cnt_d      = cnt + CNT_W'(1);
        end

        // A strobe while open replaces the window on this same edge.
        if (note_valid) begin
          if (|notes) begin
            state_d    = OPEN;
            expected_d = notes;
            hit_mask_d = '0;
            cnt_d      = '0;
          end else begin
            state_d    = IDLE;
          end
        end
      end
    endcase
  end

  // Saturating score/combo arithmetic for the candidate update.
  always_comb begin
    pts        = (grade == J_GREAT) ? AW'(GREAT_PTS) : AW'(GOOD_PTS);
    sum        = AW'(score) + pts;
    score_hit  = (|sum[AW-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];
    score_miss = (AW'(score) < AW'(MISS_PTS)) ? '0 : score - SCORE_W'(MISS_PTS);
    combo_hit  = (&combo) ? combo : combo + COMBO_W'(1);
    max_hit    = (combo_hit > max_combo) ? combo_hit : max_combo;
  end

  // Window state, lane bookkeeping and input history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      expected    <= '0;
      hit_mask    <= '0;
      prev_input  <= '0;
      window_open <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      expected    <= expected_d;
      hit_mask    <= hit_mask_d;
      prev_input  <= player_input;
      window_open <= (state_d == OPEN);
    end
  end

  // One-cycle judge pulses, registered from the grading decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      judge_great <= 1'b0;
      judge_good  <= 1'b0;
      judge_miss  <= 1'b0;
    end else begin
      judge_great <= (grade == J_GREAT);
      judge_good  <= (grade == J_GOOD);
      judge_miss  <= (grade == J_MISS);
    end
  end

  // Score and combo; clear_stats beats a same-edge grade update.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else begin
      case (grade)
        J_GREAT, J_GOOD: begin
          score     <= score_hit;
          combo     <= combo_hit;
          max_combo <= max_hit;
        end
        J_MISS: begin
          score     <= score_miss;
          combo     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: a directed vector table, hand-written corner
// sequences and random stimulus, all checked against a reference model.
// Two instances: defaults, and SCORE_W=9 with stray presses not penalised.
module tb_hit_judge;

  localparam int W_LEN = 8;
  localparam int W_GRT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1, note_valid = 1'b0, clear_stats = 1'b0;
  logic [2:0] notes = '0, player_input = '0;

  logic       o1_open, o1_g, o1_d, o1_m;
  logic [15:0] o1_score;
  logic [9:0] o1_combo, o1_max;
  logic       o2_open, o2_g, o2_d, o2_m;
  logic [8:0] o2_score;
  logic [9:0] o2_combo, o2_max;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  hit_judge dut1 (
    .clk(clk), .reset(reset), .note_valid(note_valid), .notes(notes),
    .player_input(player_input), .clear_stats(clear_stats),
    .window_open(o1_open), .judge_great(o1_g), .judge_good(o1_d), .judge_miss(o1_m),
    .score(o1_score), .combo(o1_combo), .max_combo(o1_max));

  hit_judge #(.SCORE_W(9), .PENALISE_STRAY(0)) dut2 (
    .clk(clk), .reset(reset), .note_valid(note_valid), .notes(notes),
    .player_input(player_input), .clear_stats(clear_stats),
    .window_open(o2_open), .judge_great(o2_g), .judge_good(o2_d), .judge_miss(o2_m),
    .score(o2_score), .combo(o2_combo), .max_combo(o2_max));

  // Reference model: one pending note with its required and collected lanes.
  typedef struct packed {
    bit open; int age; bit [2:0] need; bit [2:0] got; bit [2:0] prev;
    int score; int combo; int maxc; bit g; bit d; bit m;
  } mdl_t;

  mdl_t m1 = '0, m2 = '0;

  function automatic mdl_t step(mdl_t s, logic rst, logic nv, logic [2:0] nt,
                                logic [2:0] pi, logic cs, int smax, bit stray);
    mdl_t n;
    bit [2:0] r;
    int grade; // 0 none, 1 great, 2 good, 3 miss
    n = s; n.g = 0; n.d = 0; n.m = 0; grade = 0;
    if (rst) begin
      n = '0;
    end else begin
      r = pi & ~s.prev;
      n.prev = pi;
      if (!s.open) begin
        if (nv) begin
          if (nt != 0) begin n.open = 1; n.need = nt; n.got = 0; n.age = 0; end
        end else if (r != 0 && stray) grade = 3;
      end else begin
        if ((r & ~s.need) != 0)           grade = 3;
        else if ((s.got | r) == s.need)   grade = (s.age < W_GRT) ? 1 : 2;
        else if (nv || s.age == W_LEN-1)  grade = 3;
        if (grade != 0) n.open = 0;
        else begin n.got = s.got | r; n.age = s.age + 1; end
        if (nv) begin n.open = (nt != 0); n.need = nt; n.got = 0; n.age = 0; end
      end
      n.g = (grade == 1); n.d = (grade == 2); n.m = (grade == 3);
      if (cs) begin
        n.score = 0; n.combo = 0; n.maxc = 0;
      end else if (grade == 1 || grade == 2) begin
        n.score = s.score + ((grade == 1) ? 300 : 100);
        if (n.score > smax) n.score = smax;
        n.combo = (s.combo < 1023) ? s.combo + 1 : 1023;
        n.maxc  = (n.combo > s.maxc) ? n.combo : s.maxc;
      end else if (grade == 3) begin
        n.score = (s.score > 50) ? s.score - 50 : 0;
        n.combo = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m1 <= step(m1, reset, note_valid, notes, player_input, clear_stats, 65535, 1'b1);
    m2 <= step(m2, reset, note_valid, notes, player_input, clear_stats, 511, 1'b0);
  end

  function automatic logic [63:0] pk(logic o, logic g, logic d, logic m, int s, int c, int x);
    return {24'd0, o, g, d, m, 16'(s), 10'(c), 10'(x)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] d1();
    return pk(o1_open, o1_g, o1_d, o1_m, int'(o1_score), int'(o1_combo), int'(o1_max));
  endfunction
  function automatic logic [63:0] d2();
    return pk(o2_open, o2_g, o2_d, o2_m, int'(o2_score), int'(o2_combo), int'(o2_max));
  endfunction

  // Advance one edge, then compare both instances with the model.
  task automatic cycle();
    @(posedge clk);
    #1;
    chk("model_dut1", d1(), pk(m1.open, m1.g, m1.d, m1.m, m1.score, m1.combo, m1.maxc));
    chk("model_dut2", d2(), pk(m2.open, m2.g, m2.d, m2.m, m2.score, m2.combo, m2.maxc));
  endtask

  task automatic drive(input int rst, input int nv, input int nt, input int pi, input int cs);
    reset = 1'(rst); note_valid = 1'(nv); notes = 3'(nt);
    player_input = 3'(pi); clear_stats = 1'(cs);
  endtask

  typedef struct {
    int rst, nv, nt, pi, cs;
    int op, g, d, m, sc, cb, mx;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int rst, input int nv, input int nt, input int pi, input int cs,
                     input int op, input int g, input int d, input int m,
                     input int sc, input int cb, input int mx);
    vec_t v;
    v = '{rst, nv, nt, pi, cs, op, g, d, m, sc, cb, mx};
    tbl.push_back(v);
  endtask

  initial begin
    // Expected outputs of the default instance after each edge.
    add(1,0,0,0,0, 0,0,0,0,   0,0,0);  // reset
    add(0,1,1,0,0, 1,0,0,0,   0,0,0);  // note 001
    add(0,0,0,0,0, 1,0,0,0,   0,0,0);  // cnt0
    add(0,0,0,1,0, 0,1,0,0, 300,1,1);  // lane0 at cnt1 -> GREAT
    add(0,0,0,0,0, 0,0,0,0, 300,1,1);
    add(0,1,3,0,0, 1,0,0,0, 300,1,1);  // note 011
    add(0,0,0,1,0, 1,0,0,0, 300,1,1);  // partial hit
    add(1,0,0,0,0, 0,0,0,0,   0,0,0);  // reset mid-window
    add(0,0,0,2,0, 0,0,0,1,   0,0,0);  // stray lane1 -> MISS, floor 0
    add(0,0,0,0,0, 0,0,0,0,   0,0,0);
    add(0,1,1,0,0, 1,0,0,0,   0,0,0);  // note 001
    add(0,0,0,0,0, 1,0,0,0,   0,0,0);
    add(0,0,0,1,0, 0,1,0,0, 300,1,1);  // GREAT
    add(0,0,0,0,0, 0,0,0,0, 300,1,1);
    add(0,1,5,0,0, 1,0,0,0, 300,1,1);  // note 101
    add(0,0,0,0,0, 1,0,0,0, 300,1,1);
    add(0,0,0,1,0, 1,0,0,0, 300,1,1);  // lane0 at cnt1
    add(0,0,0,0,0, 1,0,0,0, 300,1,1);
    add(0,0,0,0,0, 1,0,0,0, 300,1,1);
    add(0,0,0,0,0, 1,0,0,0, 300,1,1);
    add(0,0,0,4,0, 0,0,1,0, 400,2,2);  // lane2 at cnt5 -> GOOD
    add(0,0,0,0,0, 0,0,0,0, 400,2,2);
    add(0,1,2,0,0, 1,0,0,0, 400,2,2);  // note 010
    add(0,0,0,4,0, 0,0,0,1, 350,0,2);  // wrong lane -> MISS
    add(0,0,0,0,0, 0,0,0,0, 350,0,2);
    add(0,1,2,0,0, 1,0,0,0, 350,0,2);  // note 010, never pressed
    for (int i = 0; i < W_LEN-1; i++) add(0,0,0,0,0, 1,0,0,0, 350,0,2);
    add(0,0,0,0,0, 0,0,0,1, 300,0,2);  // timeout at cnt=WINDOW-1
    add(0,1,1,0,0, 1,0,0,0, 300,0,2);  // note 001
    add(0,0,0,0,0, 1,0,0,0, 300,0,2);
    add(0,1,4,0,0, 1,0,0,1, 250,0,2);  // new note while open -> MISS, stays open
    add(0,0,0,4,0, 0,1,0,0, 550,1,2);  // GREAT for the new note
    add(0,0,0,0,0, 0,0,0,0, 550,1,2);
    add(0,1,2,0,0, 1,0,0,0, 550,1,2);
    add(0,0,0,2,1, 0,1,0,0,   0,0,0);  // clear_stats with GREAT
    add(0,0,0,0,0, 0,0,0,0,   0,0,0);
    add(0,1,1,0,0, 1,0,0,0,   0,0,0);
    add(0,0,0,0,1, 1,0,0,0,   0,0,0);  // clear_stats keeps window
    add(0,0,0,1,0, 0,1,0,0, 300,1,1);  // GREAT at cnt1
    add(0,0,0,0,0, 0,0,0,0, 300,1,1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].nv, tbl[i].nt, tbl[i].pi, tbl[i].cs);
      cycle();
      chk($sformatf("vec%0d", i), d1(),
          pk(1'(tbl[i].op), 1'(tbl[i].g), 1'(tbl[i].d), 1'(tbl[i].m),
             tbl[i].sc, tbl[i].cb, tbl[i].mx));
    end

    // Saturation at SCORE_W=9 and stray handling difference.
    drive(1,0,0,0,0); cycle();
    chk("sat_reset", d2(), pk(0,0,0,0, 0,0,0));
    drive(0,1,1,0,0); cycle();
    drive(0,0,0,1,0); cycle();
    chk("sat_great1", d2(), pk(0,1,0,0, 300,1,1));
    drive(0,1,1,0,0); cycle();
    drive(0,0,0,1,0); cycle();
    chk("sat_great2", d2(), pk(0,1,0,0, 511,2,2));
    chk("nosat_great2", d1(), pk(0,1,0,0, 600,2,2));
    drive(0,0,0,0,0); cycle();
    drive(0,0,0,4,0); cycle();
    chk("stray_ignored", d2(), pk(0,0,0,0, 511,2,2));
    chk("stray_penalised", d1(), pk(0,0,0,1, 550,0,2));
    drive(0,0,0,0,0); cycle();

    // Completing press on the same edge as the next strobe.
    drive(0,1,2,0,0); cycle();
    drive(0,1,1,2,0); cycle();
    chk("overlap_great", d1(), pk(1,1,0,0, 850,1,2));
    drive(0,0,0,3,0); cycle();
    chk("overlap_next", d1(), pk(0,1,0,0, 1150,2,2));
    chk("overlap_next_sat", d2(), pk(0,1,0,0, 511,4,4));
    drive(0,0,0,0,0); cycle();

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      note_valid   = ($urandom_range(0, 4) == 0);
      notes        = 3'($urandom_range(0, 7));
      clear_stats  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 0 && m1.open)
        player_input = player_input | m1.need;
      else
        player_input = player_input ^ (3'($urandom) & 3'($urandom));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
